// File: rtl/glb_wr_packer.sv
// glb_wr_packer: packs narrow input beats into a wide
// multi-bank GLB write word with a per-transfer budget.
module glb_wr_packer #(
  parameter int IN_WIDTH   = 64,
  parameter int SRAM_WIDTH = 256,
  parameter int MAXPAR     = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           CfgVld,
  output logic                           CfgRdy,
  input  logic [$clog2(MAXPAR):0]        CfgParBank,
  input  logic [ADDR_WIDTH-1:0]          CfgNumWord,
  input  logic [IN_WIDTH-1:0]            InDat,
  input  logic                           InVld,
  input  logic                           InLast,
  output logic                           InRdy,
  output logic [SRAM_WIDTH*MAXPAR-1:0]   OutDat,
  output logic                           OutVld,
  input  logic                           OutRdy,
  output logic                           Fnh,
  output logic                           Busy
);

  localparam int PW    = $clog2(MAXPAR) + 1;
  localparam int RATIO = SRAM_WIDTH / IN_WIDTH;
  localparam int NL    = MAXPAR * RATIO;
  localparam int BW    = $clog2(NL + 1);
  localparam int OW    = SRAM_WIDTH * MAXPAR;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    WORK,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BW-1:0]         bpw_q;
  logic [BW-1:0]         beat_cnt_q;
  logic [ADDR_WIDTH-1:0] nw_q;
  logic [ADDR_WIDTH-1:0] word_cnt_q;
  logic                  lws_q;
  logic [OW-1:0]         asm_q;
  logic [OW-1:0]         word_in;

  logic          cfg_fire;
  logic          in_fire;
  logic          out_fire;
  logic          completing;
  logic          final_ld;
  logic [PW-1:0] par_c;
  logic [BW-1:0] bpw_c;
  logic [CW-1:0] ld_idx;

  assign CfgRdy = (state_q == IDLE);
  assign Busy   = (state_q != IDLE);
  assign Fnh    = (state_q == DONE);

  assign cfg_fire = CfgVld & CfgRdy;

  assign completing =
    (beat_cnt_q == (bpw_q - BW'(1))) | InLast;

  assign InRdy = (state_q == WORK) & ~lws_q &
                 (~completing | ~OutVld | OutRdy);

  assign in_fire  = InVld & InRdy;
  assign out_fire = OutVld & OutRdy;

  // A pending output word counts toward the index
  // of the word being loaded now.
  assign ld_idx = CW'(word_cnt_q) + CW'(OutVld);

  assign final_ld =
    InLast | (ld_idx == (CW'(nw_q) - CW'(1)));

  // Clamp the bank count and derive beats per word.
  always_comb begin
    par_c = CfgParBank;
    if (CfgParBank == '0) begin
      par_c = PW'(1);
    end else if (CfgParBank > PW'(MAXPAR)) begin
      par_c = PW'(MAXPAR);
    end
    bpw_c = BW'(par_c) * BW'(RATIO);
  end

  // Assembly buffer with the current beat merged in.
  always_comb begin
    word_in = asm_q;
    for (int i = 0; i < NL; i++) begin
      if (beat_cnt_q == BW'(i)) begin
        word_in[i*IN_WIDTH +: IN_WIDTH] = InDat;
      end
    end
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cfg_fire) state_d = WORK;
      WORK: if (out_fire & lws_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the per-transfer geometry and budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpw_q <= '0;
      nw_q  <= '0;
    end else if (cfg_fire) begin
      bpw_q <= bpw_c;
      if (CfgNumWord == '0) begin
        nw_q <= ADDR_WIDTH'(1);
      end else begin
        nw_q <= CfgNumWord;
      end
    end
  end

  // Beat counter and assembly buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
    end else if (cfg_fire) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
    end else if (in_fire) begin
      if (completing) begin
        beat_cnt_q <= '0;
        asm_q      <= '0;
      end else begin
        beat_cnt_q <= beat_cnt_q + BW'(1);
        asm_q      <= word_in;
      end
    end
  end

  // Word counter and final-word-loaded flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      lws_q      <= 1'b0;
    end else if (cfg_fire) begin
      word_cnt_q <= '0;
      lws_q      <= 1'b0;
    end else begin
      if (out_fire) begin
        word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
      if (in_fire & completing & final_ld) begin
        lws_q <= 1'b1;
      end
    end
  end

  // Output word register; a new load wins over
  // the handshake clearing OutVld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutDat <= '0;
      OutVld <= 1'b0;
    end else if (in_fire & completing) begin
      OutDat <= word_in;
      OutVld <= 1'b1;
    end else if (out_fire) begin
      OutVld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_glb_wr_packer.sv
// tb_glb_wr_packer: vector table plus randomized
// transfers checked against a beat-list word model.
module tb_glb_wr_packer;

  localparam int OW = 8192;
  localparam int NL = 128;

  logic            clk;
  logic            rst_n;
  logic            CfgVld;
  logic            CfgRdy;
  logic [5:0]      CfgParBank;
  logic [15:0]     CfgNumWord;
  logic [63:0]     InDat;
  logic            InVld;
  logic            InLast;
  logic            InRdy;
  logic [OW-1:0]   OutDat;
  logic            OutVld;
  logic            OutRdy;
  logic            Fnh;
  logic            Busy;

  glb_wr_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CfgVld     (CfgVld),
    .CfgRdy     (CfgRdy),
    .CfgParBank (CfgParBank),
    .CfgNumWord (CfgNumWord),
    .InDat      (InDat),
    .InVld      (InVld),
    .InLast     (InLast),
    .InRdy      (InRdy),
    .OutDat     (OutDat),
    .OutVld     (OutVld),
    .OutRdy     (OutRdy),
    .Fnh        (Fnh),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cyc[$];
  int hs_cyc[$];

  typedef struct {
    int par;
    int nw;
    int last_at;
    int rdy;
    int vld;
    bit poke;
    int exp_acc;
    int exp_words;
  } vec_t;

  task automatic chk(string nm, longint act,
                     longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_word(string nm,
                          logic [OW-1:0] act,
                          logic [OW-1:0] exp);
    int ln;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      ln = 0;
      for (int i = NL - 1; i >= 0; i--)
        if (act[i*64 +: 64] !== exp[i*64 +: 64])
          ln = i;
      $display("FAIL %s lane %0d got %h exp %h",
               nm, ln, act[ln*64 +: 64],
               exp[ln*64 +: 64]);
    end
  endtask

  task automatic idle_inputs();
    CfgVld     = 1'b0;
    CfgParBank = '0;
    CfgNumWord = '0;
    InVld      = 1'b0;
    InLast     = 1'b0;
    InDat      = '0;
    OutRdy     = 1'b0;
  endtask

  task automatic do_cfg(int par, int nw);
    @(negedge clk);
    CfgVld     = 1'b1;
    CfgParBank = 6'(par);
    CfgNumWord = 16'(nw);
    #1;
    chk("cfg_rdy", CfgRdy, 1);
    @(posedge clk);
    #1;
    CfgVld = 1'b0;
  endtask

  // Words are built straight from the beat list:
  // word k holds beats k*bpw .. k*bpw+bpw-1.
  task automatic run_xfer(int par, int nw,
                          int last_at, int rdy_pct,
                          int vld_pct, bit poke,
                          output int acc,
                          output int words);
    int eff_par, bpw, enw, cap;
    int exp_acc, ntot, idx, cyc;
    bit fnh_exp, fnh_next, done;
    logic [63:0]   beats[$];
    logic [OW-1:0] expq[$];
    logic [OW-1:0] w;
    eff_par = (par == 0) ? 1 : (par > 32 ? 32 : par);
    bpw = eff_par * 4;
    enw = (nw == 0) ? 1 : nw;
    cap = enw * bpw;
    exp_acc = (last_at >= 0 && last_at + 1 < cap)
              ? last_at + 1 : cap;
    ntot = (last_at >= 0 ? last_at + 1 : cap) + 3;
    for (int i = 0; i < ntot; i++)
      beats.push_back({$urandom, $urandom});
    for (int k = 0; k * bpw < exp_acc; k++) begin
      w = '0;
      for (int j = 0; j < bpw; j++)
        if (k * bpw + j < exp_acc)
          w[j*64 +: 64] = beats[k*bpw + j];
      expq.push_back(w);
    end
    acc_cyc.delete();
    hs_cyc.delete();
    acc = 0;
    words = 0;
    idx = 0;
    fnh_exp = 1'b0;
    done = 1'b0;
    do_cfg(par, nw);
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      CfgVld     = poke && (cyc == 0);
      CfgParBank = 6'd5;
      CfgNumWord = 16'd9;
      InVld  = (idx < ntot) &&
               ($urandom_range(99) < vld_pct);
      InDat  = (idx < ntot) ? beats[idx] : 64'd0;
      InLast = (idx == last_at);
      OutRdy = ($urandom_range(99) < rdy_pct);
      #1;
      if (poke && cyc == 0)
        chk("cfg_ignored", CfgRdy, 0);
      chk("fnh", Fnh, fnh_exp);
      if (fnh_exp) done = 1'b1;
      fnh_next = 1'b0;
      if (InVld && InRdy) begin
        idx++;
        acc++;
        acc_cyc.push_back(cyc);
      end
      if (OutVld && OutRdy) begin
        hs_cyc.push_back(cyc);
        words++;
        if (expq.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk_word("word", OutDat, expq.pop_front());
          if (expq.size() == 0) fnh_next = 1'b1;
        end
      end
      fnh_exp = fnh_next;
    end
    chk("timeout", done, 1);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("idle_rdy", CfgRdy, 1);
    chk("idle_busy", Busy, 0);
    chk("idle_outvld", OutVld, 0);
  endtask

  initial begin
    vec_t vt[10];
    int a, wd, hs, fn;
    logic [63:0]   b[$];
    logic [OW-1:0] snap, ew;
    bit have;

    vt[0] = '{1, 2, -1, 100, 100, 0, 8, 2};
    vt[1] = '{1, 4, 1, 100, 100, 0, 2, 1};
    vt[2] = '{0, 1, -1, 100, 100, 0, 4, 1};
    vt[3] = '{40, 1, -1, 70, 80, 0, 128, 1};
    vt[4] = '{1, 0, -1, 100, 100, 0, 4, 1};
    vt[5] = '{3, 3, -1, 50, 60, 0, 36, 3};
    vt[6] = '{2, 3, 13, 60, 70, 0, 14, 2};
    vt[7] = '{1, 2, 20, 100, 100, 0, 8, 2};
    vt[8] = '{1, 2, -1, 50, 100, 1, 8, 2};
    vt[9] = '{32, 2, 150, 40, 90, 0, 151, 2};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outvld", OutVld, 0);
    chk("rst_fnh", Fnh, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_cfgrdy", CfgRdy, 1);
    chk("rst_inrdy", InRdy, 0);
    chk_word("rst_outdat", OutDat, '0);
    rst_n = 1'b1;

    for (int t = 0; t < 10; t++) begin
      run_xfer(vt[t].par, vt[t].nw, vt[t].last_at,
               vt[t].rdy, vt[t].vld, vt[t].poke,
               a, wd);
      chk($sformatf("vec%0d_beats", t),
          a, vt[t].exp_acc);
      chk($sformatf("vec%0d_words", t),
          wd, vt[t].exp_words);
    end

    run_xfer(1, 3, -1, 100, 100, 0, a, wd);
    chk("stream_beats", a, 12);
    chk("stream_words", wd, 3);
    if (acc_cyc.size() == 12 && hs_cyc.size() == 3) begin
      chk("stream_span", acc_cyc[11] - acc_cyc[0], 11);
      chk("stream_lat", hs_cyc[0] - acc_cyc[3], 1);
      chk("stream_gap1", hs_cyc[1] - hs_cyc[0], 4);
      chk("stream_gap2", hs_cyc[2] - hs_cyc[1], 4);
    end else begin
      chk("stream_sizes", hs_cyc.size(), 3);
    end

    for (int i = 0; i < 10; i++)
      b.push_back({$urandom, $urandom});
    do_cfg(2, 1);
    a = 0;
    have = 1'b0;
    snap = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      InVld  = 1'b1;
      InDat  = b[a];
      InLast = 1'b0;
      OutRdy = 1'b0;
      #1;
      if (OutVld) begin
        if (!have) begin
          snap = OutDat;
          have = 1'b1;
        end else begin
          chk_word("stall_hold", OutDat, snap);
        end
      end
      if (InVld && InRdy) a++;
    end
    chk("stall_beats", a, 8);
    chk("stall_outvld", OutVld, 1);
    chk("stall_inrdy", InRdy, 0);
    ew = '0;
    for (int j = 0; j < 8; j++) ew[j*64 +: 64] = b[j];
    chk_word("stall_word", OutDat, ew);
    hs = 0;
    fn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      OutRdy = 1'b1;
      InDat  = b[a];
      #1;
      if (OutVld && OutRdy) hs++;
      if (InVld && InRdy) a++;
      if (Fnh) fn++;
    end
    chk("stall_hs", hs, 1);
    chk("stall_fnh", fn, 1);
    chk("stall_nomore", a, 8);
    idle_inputs();

    do_cfg(1, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      InVld  = 1'b1;
      InDat  = {$urandom, $urandom};
      InLast = 1'b0;
      OutRdy = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mrst_outvld", OutVld, 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_fnh", Fnh, 0);
    chk("mrst_cfgrdy", CfgRdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(1, 1, 1, 100, 100, 0, a, wd);
    chk("mrst_beats", a, 2);
    chk("mrst_words", wd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
